// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control unit: Moore sequencer, NZCV register and condition evaluation.
// Optional iterative multiply state is enabled by defining MULTICYCLE_MUL_EN.
module multicycle_controller #(
    parameter int MUL_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] Mul,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic       MulStart,
    output logic       Undef,
    output logic [3:0] Flags
);
    typedef enum logic [3:0] {
        RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXECR, EXECI, ALUWB, BRANCH, MULEX
    } state_t;

    localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);

    state_t     state;
    state_t     dec_next;
    logic       dec_undef;
    logic [3:0] mul_cnt;
    logic [3:0] flags_q;
    logic [3:0] cmd;
    logic       n_f, z_f, c_f, v_f;
    logic       cond_ex;
    logic       cmd_ok;
    logic       is_mul;
    logic       is_arith;
    logic [2:0] alu_dec;

    assign Flags    = flags_q;
    assign cmd      = Funct[4:1];
    assign {n_f, z_f, c_f, v_f} = flags_q;
    assign is_mul   = (Op == 2'b00) && (cmd == 4'b0000) && (Mul == 4'b1001);
    assign is_arith = (cmd == 4'b0100) || (cmd == 4'b0010);

    always_comb begin
        case (Cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = !z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = !c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = !n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = !v_f;
            4'b1000: cond_ex = c_f && !z_f;
            4'b1001: cond_ex = !c_f || z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = !z_f && (n_f == v_f);
            4'b1101: cond_ex = z_f || (n_f != v_f);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        cmd_ok  = 1'b1;
        alu_dec = 3'b000;
        case (cmd)
            4'b0100: alu_dec = 3'b000;
            4'b0010: alu_dec = 3'b001;
            4'b0000: alu_dec = 3'b010;
            4'b1100: alu_dec = 3'b011;
            4'b1101: alu_dec = 3'b101;
            default: cmd_ok  = 1'b0;
        endcase
    end

    // The multiply pattern is checked before the command table so that it
    // never falls through to AND.
    always_comb begin
        dec_next  = FETCH;
        dec_undef = 1'b0;
        if (cond_ex) begin
            case (Op)
                2'b01: dec_next = MEMADR;
                2'b10: dec_next = BRANCH;
                2'b11: dec_undef = 1'b1;
                default: begin
                    if (is_mul) begin
`ifdef MULTICYCLE_MUL_EN
                        dec_next = MULEX;
`else
                        dec_undef = 1'b1;
`endif
                    end else if (!cmd_ok) begin
                        dec_undef = 1'b1;
                    end else if (Funct[5]) begin
                        dec_next = EXECI;
                    end else begin
                        dec_next = EXECR;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= RST;
            mul_cnt <= 4'd0;
            flags_q <= 4'd0;
        end else begin
            case (state)
                RST:    state <= FETCH;
                FETCH:  state <= DECODE;
                DECODE: state <= dec_next;
                MEMADR: state <= Funct[0] ? MEMRD : MEMWR;
                MEMRD:  state <= MEMWB;
                MEMWB:  state <= FETCH;
                MEMWR:  state <= FETCH;
                EXECR:  state <= ALUWB;
                EXECI:  state <= ALUWB;
                BRANCH: state <= FETCH;
                ALUWB: begin
                    state <= FETCH;
                    if (Funct[0]) begin
                        flags_q[3:2] <= ALUFlags[3:2];
                        if (is_arith) flags_q[1:0] <= ALUFlags[1:0];
                    end
                end
                MULEX: begin
                    if (mul_cnt == MUL_LAST) begin
                        mul_cnt <= 4'd0;
                        state   <= ALUWB;
                    end else begin
                        mul_cnt <= mul_cnt + 4'd1;
                    end
                end
                default: state <= RST;
            endcase
        end
    end

    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 3'b000;
        ImmSrc     = 2'b00;
        RegSrc     = 2'b00;
        MulStart   = 1'b0;
        Undef      = 1'b0;
        if (state != RST) begin
            ImmSrc = Op;
            RegSrc = {Op == 2'b01, Op == 2'b10};
        end
        case (state)
            FETCH: begin
                IRWrite = 1'b1; PCWrite = 1'b1; ALUSrcA = 1'b1;
                ALUSrcB = 2'b10; ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
                Undef = dec_undef;
            end
            MEMADR: ALUSrcB = 2'b01;
            MEMRD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01; RegWrite = 1'b1;
            end
            MEMWR: begin
                AdrSrc = 1'b1; MemWrite = 1'b1;
            end
            EXECR: ALUControl = alu_dec;
            EXECI: begin
                ALUSrcB = 2'b01; ALUControl = alu_dec;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                PCWrite  = (Rd == 4'd15);
`ifdef MULTICYCLE_MUL_EN
                ResultSrc = is_mul ? 2'b11 : 2'b00;
`endif
            end
            BRANCH: begin
                ALUSrcB = 2'b01; ResultSrc = 2'b10; PCWrite = 1'b1;
            end
            MULEX: begin
`ifdef MULTICYCLE_MUL_EN
                MulStart = (mul_cnt == 4'd0);
`endif
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: vector table, hand-written reset corners and
// random instructions checked against an instruction-level cycle model.
module tb_multicycle_controller;
    localparam int MC = 4;
`ifdef MULTICYCLE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] Cond = 4'd0;
    logic [1:0] Op = 2'd0;
    logic [5:0] Funct = 6'd0;
    logic [3:0] Rd = 4'd0;
    logic [3:0] Mul = 4'd0;
    logic [3:0] ALUFlags = 4'd0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc;
    logic [2:0] ALUControl;
    logic       MulStart, Undef;
    logic [3:0] Flags;

    multicycle_controller #(.MUL_CYCLES(MC)) dut (
        .clk(clk), .reset_n(reset_n), .Cond(Cond), .Op(Op), .Funct(Funct),
        .Rd(Rd), .Mul(Mul), .ALUFlags(ALUFlags), .PCWrite(PCWrite),
        .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
        .RegSrc(RegSrc), .MulStart(MulStart), .Undef(Undef), .Flags(Flags)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [3:0]  mflags = 4'd0;
    logic [3:0]  mflags_next = 4'd0;
    logic [22:0] exp_q[$];

    typedef struct {
        logic [3:0] cond;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        logic [3:0] mul;
        logic [3:0] af;
        int         lat;
        logic [3:0] flags;
    } vec_t;
    vec_t vt[13];

    function automatic logic [22:0] act();
        return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, ALUSrcB,
                ResultSrc, ALUControl, ImmSrc, RegSrc, MulStart, Undef, Flags};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ARM condition table: pairs of codes share a base test, odd codes invert it.
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic r;
        case (c[3:1])
            3'd0: r = f[2];
            3'd1: r = f[1];
            3'd2: r = f[3];
            3'd3: r = f[0];
            3'd4: r = f[1] && !f[2];
            3'd5: r = (f[3] == f[0]);
            3'd6: r = !f[2] && (f[3] == f[0]);
            default: r = 1'b1;
        endcase
        if (c == 4'b1111) return 1'b0;
        return c[0] ? !r : r;
    endfunction

    function automatic logic [22:0] w(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic rw, input logic sa,
                                      input logic [1:0] sb, input logic [1:0] rs,
                                      input logic [2:0] ac, input logic ms, input logic ud,
                                      input logic [1:0] op);
        return {pcw, adr, mw, irw, rw, sa, sb, rs, ac, op, op == 2'b01, op == 2'b10,
                ms, ud, mflags};
    endfunction

    // Expected per-cycle outputs of one instruction, FETCH through its last cycle.
    task automatic build_expect(input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                                input logic [3:0] rd, input logic [3:0] m, input logic [3:0] af);
        logic [3:0] cmd;
        logic       ok, mulp, ud;
        logic [2:0] ac;
        cmd = f[4:1];
        exp_q.delete();
        mflags_next = mflags;
        exp_q.push_back(w(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 2'b10, 3'b000, 1'b0, 1'b0, op));
        if (!cond_pass(c, mflags)) begin
            exp_q.push_back(w(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 3'b000, 1'b0, 1'b0, op));
            return;
        end
        ok = 1'b1;
        ac = 3'b000;
        if (cmd == 4'b0100) ac = 3'b000;
        else if (cmd == 4'b0010) ac = 3'b001;
        else if (cmd == 4'b0000) ac = 3'b010;
        else if (cmd == 4'b1100) ac = 3'b011;
        else if (cmd == 4'b1101) ac = 3'b101;
        else ok = 1'b0;
        mulp = (op == 2'b00) && (cmd == 4'b0000) && (m == 4'b1001);
        ud = (op == 2'b11) || ((op == 2'b00) && (mulp ? !MUL_EN : !ok));
        exp_q.push_back(w(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 3'b000, 1'b0, ud, op));
        if (ud) return;
        if (op == 2'b01) begin
            exp_q.push_back(w(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0, op));
            if (f[0]) begin
                exp_q.push_back(w(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, op));
                exp_q.push_back(w(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 3'b000, 1'b0, 1'b0, op));
            end else begin
                exp_q.push_back(w(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, op));
            end
        end else if (op == 2'b10) begin
            exp_q.push_back(w(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 3'b000, 1'b0, 1'b0, op));
        end else begin
            if (mulp) begin
                for (int i = 0; i < MC; i++)
                    exp_q.push_back(w(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000,
                                      i == 0, 1'b0, op));
                exp_q.push_back(w(rd == 4'd15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b11, 3'b000,
                                  1'b0, 1'b0, op));
            end else begin
                exp_q.push_back(w(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, f[5] ? 2'b01 : 2'b00, 2'b00,
                                  ac, 1'b0, 1'b0, op));
                exp_q.push_back(w(rd == 4'd15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 3'b000,
                                  1'b0, 1'b0, op));
            end
            if (f[0]) begin
                mflags_next[3:2] = af[3:2];
                if (cmd == 4'b0100 || cmd == 4'b0010) mflags_next[1:0] = af[1:0];
            end
        end
    endtask

    // Called at posedge+1 of a FETCH cycle; returns at posedge+1 of the next FETCH.
    task automatic run_instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                             input logic [3:0] rd, input logic [3:0] m, input logic [3:0] af,
                             output int lat);
        build_expect(c, op, f, rd, m, af);
        Cond = c; Op = op; Funct = f; Rd = rd; Mul = m; ALUFlags = af;
        lat = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            lat++;
            if (exp_q.size() > 0) check("cycle", 32'(act()), 32'(exp_q.pop_front()));
            else fail_now("cycle overrun");
            @(posedge clk);
            #1;
            if (IRWrite) break;
        end
        if (!IRWrite) fail_now("timeout waiting for FETCH");
        if (exp_q.size() != 0) fail_now("instruction ended early");
        mflags = mflags_next;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [3:0] c, rd, m, af, cmd;
        logic [1:0] op;
        logic [3:0] cmds[5];
        cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1101};

        vt[0]  = '{4'b0000, 2'b10, 6'b100000, 4'd0,  4'b0000, 4'b0000, 2, 4'b0000};
        vt[1]  = '{4'b1110, 2'b00, 6'b001001, 4'd1,  4'b0000, 4'b0110, 4, 4'b0110};
        vt[2]  = '{4'b0000, 2'b10, 6'b100000, 4'd0,  4'b0000, 4'b0000, 3, 4'b0110};
        vt[3]  = '{4'b1110, 2'b01, 6'b011001, 4'd3,  4'b0000, 4'b0000, 5, 4'b0110};
        vt[4]  = '{4'b1110, 2'b01, 6'b011000, 4'd3,  4'b0000, 4'b0000, 4, 4'b0110};
        vt[5]  = '{4'b1110, 2'b11, 6'b000000, 4'd0,  4'b0000, 4'b1111, 2, 4'b0110};
        vt[6]  = '{4'b1110, 2'b00, 6'b111011, 4'd2,  4'b0000, 4'b1011, 4, 4'b1010};
        vt[7]  = '{4'b1110, 2'b00, 6'b000101, 4'd15, 4'b0000, 4'b0011, 4, 4'b0011};
        vt[8]  = '{4'b1110, 2'b00, 6'b111000, 4'd4,  4'b0000, 4'b1111, 4, 4'b0011};
        vt[9]  = '{4'b1110, 2'b00, 6'b000010, 4'd4,  4'b0000, 4'b1111, 2, 4'b0011};
`ifdef MULTICYCLE_MUL_EN
        vt[10] = '{4'b1110, 2'b00, 6'b000001, 4'd5,  4'b1001, 4'b1101, 7, 4'b1111};
        vt[11] = '{4'b1111, 2'b00, 6'b001001, 4'd5,  4'b0000, 4'b0000, 2, 4'b1111};
        vt[12] = '{4'b0001, 2'b00, 6'b001001, 4'd5,  4'b0000, 4'b0100, 2, 4'b1111};
`else
        vt[10] = '{4'b1110, 2'b00, 6'b000001, 4'd5,  4'b1001, 4'b1101, 2, 4'b0011};
        vt[11] = '{4'b1111, 2'b00, 6'b001001, 4'd5,  4'b0000, 4'b0000, 2, 4'b0011};
        vt[12] = '{4'b0001, 2'b00, 6'b001001, 4'd5,  4'b0000, 4'b0100, 4, 4'b0100};
`endif

        // Reset held for three cycles, then one RST cycle after release.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_hold", 32'(act()), 32'd0);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst_after_release", 32'(act()), 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            run_instr(vt[i].cond, vt[i].op, vt[i].funct, vt[i].rd, vt[i].mul, vt[i].af, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].lat));
            check($sformatf("vec%0d_flags", i), 32'(Flags), 32'(vt[i].flags));
        end

        for (int i = 0; i < 150; i++) begin
            c   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b1110;
            op  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            cmd = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15))
                                              : cmds[$urandom_range(0, 4)];
            rd  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            m   = ($urandom_range(0, 2) == 0) ? 4'b1001 : 4'($urandom_range(0, 15));
            af  = 4'($urandom_range(0, 15));
            run_instr(c, op, {1'($urandom_range(0, 1)), cmd, 1'($urandom_range(0, 1))},
                      rd, m, af, lat);
            check("random_flags", 32'(Flags), 32'(mflags));
        end

        // Make Flags nonzero, then reset in the middle of an LDR.
        run_instr(4'b1110, 2'b00, 6'b001001, 4'd1, 4'b0000, 4'b1111, lat);
        check("pre_reset_flags", 32'(Flags), 32'hF);
        Cond = 4'b1110; Op = 2'b01; Funct = 6'b011001; Rd = 4'd2; Mul = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        check("memrd_reached", 32'({AdrSrc, MemWrite, RegWrite}), 32'b100);
        #2 reset_n = 1'b0;
        #1 check("async_reset_outputs", 32'(act()), 32'd0);
        @(negedge clk);
        check("reset_no_memwb_a", 32'(act()), 32'd0);
        @(posedge clk);
        #1 check("reset_no_memwb_b", 32'(act()), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_after_midreset", 32'(act()), 32'd0);
        @(posedge clk);
        #1;
        check("fetch_after_midreset", 32'({IRWrite, PCWrite, Flags}), 32'b110000);
        mflags = 4'd0;
        run_instr(4'b1110, 2'b00, 6'b001001, 4'd1, 4'b0000, 4'b0110, lat);
        check("post_reset_flags", 32'(Flags), 32'b0110);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multicycle variant of the ARM-subset processor. It replaces the single-cycle decoder path with a Moore state machine that sequences fetch, decode, execute, memory and writeback over several cycles on one shared ALU and one unified memory port. It also holds the NZCV flag register and evaluates condition codes. Multiply is an optional iterative sequence of several cycles.

## Interface
Parameters:
- MUL_CYCLES, 4, cycles spent in the multiply state (legal range 1..15)

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- Cond  in  4  Instr[31:28]
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]: [5]=I, [4:1]=cmd, [0]=S
- Rd  in  4  Instr[15:12]
- Mul  in  4  Instr[7:4]; 4'b1001 with Op=00, cmd=0000 means MUL
- ALUFlags  in  4  NZCV from the ALU
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register enable
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0=RD1, 1=PC
- ALUSrcB  out  2  00=RD2, 01=ExtImm, 10=constant 4
- ResultSrc  out  2  00=ALUOut, 01=ReadData, 10=ALU direct, 11=multiplier result
- ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 101 MOV
- ImmSrc  out  2  Op passed through
- RegSrc  out  2  [0]=Op==10, [1]=Op==01
- MulStart  out  1  one-cycle start pulse to the multiplier
- Undef  out  1  one-cycle pulse when an undefined instruction is decoded
- Flags  out  4  current NZCV register

## Operation
- States: RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, MULEX.
- While reset_n is low, the block is in RST. The first edge after release moves it to FETCH.
- RST outputs and reset values: all outputs 0, Flags=0000, multiply counter=0.
- FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, PCWrite=1. Next state is DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10 (forms PC+8). CondEx is evaluated from Flags and Cond using the standard ARM table (EQ..AL; 1111 is false). Next state:
  - CondEx=0: FETCH, with no writes.
  - Op=01: MEMADR.
  - Op=10: BRANCH.
  - Op=00 and MUL pattern: MULEX.
  - Op=00 and I=1: EXECI.
  - Op=00 otherwise: EXECR.
  - Op=11, or cmd not in {0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1101 MOV}: FETCH with Undef=1.
- MEMADR: ALUSrcB=01, ADD. Next state is MEMRD if Funct[0]=1 (LDR), otherwise MEMWR.
- MEMRD: AdrSrc=1. Next state is MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next state is FETCH.
- MEMWR: AdrSrc=1, MemWrite=1. Next state is FETCH.
- EXECR: ALUSrcB=00. EXECI: ALUSrcB=01. In both, ALUControl comes from cmd. Next state is ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. If Rd=15, PCWrite=1 as well. Next state is FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=1. Next state is FETCH.
- MULEX: MulStart=1 in the first cycle only. Stay MUL_CYCLES cycles, then go to ALUWB with ResultSrc forced to 11.
- Flag update happens on the ALUWB exit edge, only when S=1:
  - NZ are always loaded.
  - CV are loaded only for ADD/SUB.
  - MOV with S loads NZ only.
  - MEMWB never updates flags.
- ImmSrc and RegSrc are combinational from Op in every state except RST.

## Timing
- All outputs are Moore outputs decoded from the registered state. No output depends combinationally on ALUFlags.
- Instr fields must remain stable from DECODE through the last cycle of the instruction; IR is loaded only in FETCH.
- Latency in cycles, FETCH to the next FETCH:
  - Data-processing: 4
  - LDR: 5
  - STR: 4
  - B: 3
  - Condition-failed or undefined: 2
  - MUL: 3+MUL_CYCLES
- Asserting reset_n low mid-instruction returns the block to RST immediately and clears Flags. Pending writes are dropped.
- Multiply counter wraps to 0 on MULEX exit. Back-to-back MULs restart cleanly.

## Configuration
- MULTICYCLE_MUL_EN defined: MULEX is present and the MUL pattern executes as described above.
- MULTICYCLE_MUL_EN undefined:
  - The MUL pattern decodes as undefined: FETCH with an Undef pulse.
  - MulStart is tied to 0.
  - ResultSrc never equals 11.
  - MUL_CYCLES is ignored.

## Test plan
- Reset: hold reset_n=0 for 3 cycles, release → RST for one cycle with all outputs 0, then FETCH with PCWrite=IRWrite=1, Flags=0000.
- ADDS R1,R2,R3 (Cond=1110, Op=00, Funct=001001), ALUFlags=0110 → sequence FETCH,DECODE,EXECR,ALUWB; RegWrite in cycle 4; Flags=0110 afterwards.
- LDR then STR (Op=01, Funct=011001 then 011000) → LDR takes 5 cycles with ResultSrc=01 and RegWrite in MEMWB; STR takes 4 cycles with a single MemWrite pulse and AdrSrc=1.
- BEQ with Flags Z=0 → 2-cycle instruction with no PCWrite after FETCH. With Z=1 → BRANCH asserts PCWrite, ALUSrcB=01.
- MUL (Mul=1001, MUL_CYCLES=4) with the macro defined → MulStart for one cycle, 4 MULEX cycles, then ALUWB with ResultSrc=11. Without the macro → Undef pulse, back to FETCH after 2 cycles, no RegWrite.
- Op=11 → Undef=1 in DECODE, no writes. Reset asserted during MEMRD → RST at once, and MEMWB never occurs.
